// File: rtl/asip_mem_pkg.sv
// asip_mem_pkg
// Shared types and default widths for the ASIP data-memory arbiter.
//   ADDR_W_DEF / DATA_W_DEF : default word-address and data widths
//   owner_t                 : which requester the in-flight read belongs to
//   side_t                  : which requester received the most recent grant
package asip_mem_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_VGA  = 2'd2
  } owner_t;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_VGA = 1'b1
  } side_t;

endpackage

// File: rtl/asip_rr_arb2.sv
// asip_rr_arb2
// Two-way round-robin pick between CPU and VGA, with CPU lock ownership and a
// forced yield to VGA once LOCK_MAX consecutive locked CPU grants have been given.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   cpu_req, cpu_lock   CPU request and atomic-ownership request
//   vga_req             VGA request
//   cpu_win, vga_win    combinational one-hot (or zero) winner for this cycle
module asip_rr_arb2
  import asip_mem_pkg::*;
#(
  parameter int LOCK_MAX = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cpu_req,
  input  logic cpu_lock,
  input  logic vga_req,
  output logic cpu_win,
  output logic vga_win
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

  side_t            last_gnt;
  logic [CNT_W-1:0] lock_cnt;
  logic             lock_active;

  assign lock_active = (last_gnt == GNT_CPU) && cpu_req && cpu_lock && (lock_cnt < CNT_MAX);

  always_comb begin
    cpu_win = 1'b0;
    vga_win = 1'b0;
    if (cpu_req && vga_req) begin
      if (lock_active)
        cpu_win = 1'b1;
      else if (lock_cnt == CNT_MAX)
        vga_win = 1'b1;  // lock budget exhausted: VGA gets its turn
      else if (last_gnt == GNT_CPU)
        vga_win = 1'b1;
      else
        cpu_win = 1'b1;
    end else begin
      cpu_win = cpu_req;
      vga_win = vga_req;
    end
  end

  // Winners are not gated by rst_n here; the reset branch overrides any update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_gnt <= GNT_VGA;  // CPU takes the first tie out of reset
      lock_cnt <= '0;
    end else if (cpu_win) begin
      last_gnt <= GNT_CPU;
      if (!cpu_lock)
        lock_cnt <= '0;
      else if (lock_cnt != CNT_MAX)
        lock_cnt <= lock_cnt + 1'b1;
    end else if (vga_win) begin
      last_gnt <= GNT_VGA;
      lock_cnt <= '0;
    end else begin
      lock_cnt <= '0;
    end
  end

endmodule

// File: rtl/asip_mem_arbiter.sv
// asip_mem_arbiter
// Shares the single-port synchronous data RAM between the ASIP load/store unit
// and the VGA frame reader. One access is granted per cycle; read data returns
// one cycle later and is steered to whichever requester issued that read.
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   cpu_req/we/lock/addr/wdata         CPU access request
//   cpu_gnt, cpu_rvalid, cpu_rdata     CPU grant and read return
//   vga_req/addr                       VGA read request
//   vga_gnt, vga_rvalid, vga_rdata     VGA grant and read return
//   mem_en/we/addr/wdata, mem_rdata    RAM port
module asip_mem_arbiter
  import asip_mem_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int LOCK_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_lock,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic   cpu_win;
  logic   vga_win;
  owner_t rd_owner;

  asip_rr_arb2 #(
    .LOCK_MAX (LOCK_MAX)
  ) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .cpu_req  (cpu_req),
    .cpu_lock (cpu_lock),
    .vga_req  (vga_req),
    .cpu_win  (cpu_win),
    .vga_win  (vga_win)
  );

  // Grants and the RAM port stay quiet while reset is held.
  assign cpu_gnt = cpu_win & rst_n;
  assign vga_gnt = vga_win & rst_n;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (vga_gnt) begin
      mem_en    = 1'b1;
      mem_addr  = vga_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      rd_owner <= OWN_NONE;
    else if (cpu_gnt && !cpu_we)
      rd_owner <= OWN_CPU;
    else if (vga_gnt)
      rd_owner <= OWN_VGA;
    else
      rd_owner <= OWN_NONE;
  end

  // rd_owner may still name a requester during the first reset cycle, so the
  // return path is gated by rst_n as well.
  assign cpu_rvalid = rst_n && (rd_owner == OWN_CPU);
  assign vga_rvalid = rst_n && (rd_owner == OWN_VGA);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign vga_rdata  = vga_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_asip_mem_arbiter.sv
// tb_asip_mem_arbiter
// Directed bench for asip_mem_arbiter. The stimulus process drives one cycle at
// a time and queues the hand-computed expected outputs for that cycle; a
// separate monitor pops and compares on each falling edge. A small RAM model
// provides mem_rdata; its initial content is 0xA500_0000 | address.
module tb_asip_mem_arbiter;

  localparam logic [31:0] D10  = 32'hA500_0010;
  localparam logic [31:0] D200 = 32'hA500_0200;
  localparam logic [31:0] DBEF = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, cpu_lock = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_gnt, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        vga_req = 1'b0;
  logic [15:0] vga_addr = '0;
  logic        vga_gnt, vga_rvalid;
  logic [31:0] vga_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  logic [31:0] ram [0:1023];

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string       name;
    logic        cg, vg, en, we;
    logic [15:0] addr;
    logic [31:0] wd;
    logic        cv;
    logic [31:0] cd;
    logic        vv;
    logic [31:0] vd;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  asip_mem_arbiter #(
    .ADDR_W   (16),
    .DATA_W   (32),
    .LOCK_MAX (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_lock   (cpu_lock),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .vga_req    (vga_req),
    .vga_addr   (vga_addr),
    .vga_gnt    (vga_gnt),
    .vga_rvalid (vga_rvalid),
    .vga_rdata  (vga_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 32'hA500_0000 | i;
  end

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[9:0]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[9:0]];
    end
  end

  task automatic drive(input logic rst, input logic creq, input logic cwe, input logic lk,
                       input logic [15:0] ca, input logic [31:0] cw,
                       input logic vreq, input logic [15:0] va);
    @(posedge clk);
    #1;
    rst_n     = rst;
    cpu_req   = creq;
    cpu_we    = cwe;
    cpu_lock  = lk;
    cpu_addr  = ca;
    cpu_wdata = cw;
    vga_req   = vreq;
    vga_addr  = va;
  endtask

  task automatic expect_c(input string nm, input logic cg, input logic vg, input logic en,
                          input logic we, input logic [15:0] a, input logic [31:0] wd,
                          input logic cv, input logic [31:0] cd,
                          input logic vv, input logic [31:0] vd);
    exp_t e;
    e.name = nm; e.cg = cg; e.vg = vg; e.en = en; e.we = we; e.addr = a; e.wd = wd;
    e.cv = cv; e.cd = cd; e.vv = vv; e.vd = vd;
    exp_q.push_back(e);
  endtask

  // Monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if ({cpu_gnt, vga_gnt, mem_en, mem_we, mem_addr, mem_wdata,
             cpu_rvalid, cpu_rdata, vga_rvalid, vga_rdata} !==
            {e.cg, e.vg, e.en, e.we, e.addr, e.wd, e.cv, e.cd, e.vv, e.vd}) begin
          n_err++;
          $display("FAIL %s: got cg=%b vg=%b en=%b we=%b a=%h wd=%h cv=%b cd=%h vv=%b vd=%h | want cg=%b vg=%b en=%b we=%b a=%h wd=%h cv=%b cd=%h vv=%b vd=%h",
                   e.name, cpu_gnt, vga_gnt, mem_en, mem_we, mem_addr, mem_wdata,
                   cpu_rvalid, cpu_rdata, vga_rvalid, vga_rdata,
                   e.cg, e.vg, e.en, e.we, e.addr, e.wd, e.cv, e.cd, e.vv, e.vd);
        end
      end
    end
  end

  initial begin
    // Reset held 3 cycles with both requesting: everything quiet.
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0, 16'h0010, 0, 1, 16'h0200);
      expect_c("reset_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    end

    // Contention: alternate CPU, VGA, CPU, VGA with data one cycle later.
    drive(1, 1, 0, 0, 16'h0010, 0, 1, 16'h0200);
    expect_c("tie_first_cpu", 1, 0, 1, 0, 16'h0010, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 16'h0010, 0, 1, 16'h0200);
    expect_c("rr_vga_1", 0, 1, 1, 0, 16'h0200, 0, 1, D10, 0, 0);
    drive(1, 1, 0, 0, 16'h0010, 0, 1, 16'h0200);
    expect_c("rr_cpu_2", 1, 0, 1, 0, 16'h0010, 0, 0, 0, 1, D200);
    drive(1, 1, 0, 0, 16'h0010, 0, 1, 16'h0200);
    expect_c("rr_vga_2", 0, 1, 1, 0, 16'h0200, 0, 1, D10, 0, 0);
    drive(1, 0, 0, 0, 16'h0010, 0, 0, 16'h0200);
    expect_c("idle_vga_ret", 0, 0, 0, 0, 0, 0, 0, 0, 1, D200);
    drive(1, 0, 0, 0, 16'h0010, 0, 0, 16'h0200);
    expect_c("idle_quiet", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // CPU write then read-back.
    drive(1, 1, 1, 0, 16'h0004, DBEF, 0, 16'h0000);
    expect_c("cpu_write", 1, 0, 1, 1, 16'h0004, DBEF, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 16'h0004, 0, 0, 16'h0000);
    expect_c("cpu_read_back", 1, 0, 1, 0, 16'h0004, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 16'h0004, 0, 0, 16'h0000);
    expect_c("read_back_data", 0, 0, 0, 0, 0, 0, 1, DBEF, 0, 0);
    drive(1, 0, 0, 0, 16'h0004, 0, 0, 16'h0000);
    expect_c("idle_after_rb", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Lock: 8 locked CPU grants, forced yield to VGA, then CPU again.
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      expect_c("reset_pre_lock", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    end
    drive(1, 1, 0, 1, 16'h0010, 0, 1, 16'h0200);
    expect_c("lock_cpu_1", 1, 0, 1, 0, 16'h0010, 0, 0, 0, 0, 0);
    for (int i = 2; i <= 8; i++) begin
      drive(1, 1, 0, 1, 16'h0010, 0, 1, 16'h0200);
      expect_c($sformatf("lock_cpu_%0d", i), 1, 0, 1, 0, 16'h0010, 0, 1, D10, 0, 0);
    end
    drive(1, 1, 0, 1, 16'h0010, 0, 1, 16'h0200);
    expect_c("lock_yield_vga", 0, 1, 1, 0, 16'h0200, 0, 1, D10, 0, 0);
    drive(1, 1, 0, 1, 16'h0010, 0, 1, 16'h0200);
    expect_c("lock_cpu_regain", 1, 0, 1, 0, 16'h0010, 0, 0, 0, 1, D200);
    // CPU withdraws while it would have won under lock: VGA takes the cycle.
    drive(1, 0, 0, 0, 16'h0010, 0, 1, 16'h0200);
    expect_c("withdraw_vga", 0, 1, 1, 0, 16'h0200, 0, 1, D10, 0, 0);
    drive(1, 0, 0, 0, 16'h0010, 0, 0, 16'h0200);
    expect_c("withdraw_ret", 0, 0, 0, 0, 0, 0, 0, 0, 1, D200);
    drive(1, 0, 0, 0, 16'h0010, 0, 0, 16'h0200);
    expect_c("idle_after_lock", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset arriving right after a VGA read grant kills the return.
    drive(1, 0, 0, 0, 16'h0000, 0, 1, 16'h0200);
    expect_c("vga_alone", 0, 1, 1, 0, 16'h0200, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 16'h0000, 0, 0, 16'h0200);
    expect_c("reset_mid_read", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 16'h0000, 0, 0, 16'h0200);
    expect_c("post_reset_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 5; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
